// File: rtl/sample_buffer_reader_pkg.sv
// Shared types and constants for the sample buffer reader.
// Optional feature macro: SAMPLE_READER_CHECKSUM_EN (adds the trailing XOR checksum byte).
package sample_buf_pkg;

  localparam int unsigned DATA_W = 8;
  localparam logic [3:0]  HEADER_TAG = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    CSUM
  } state_t;

  // Frame header: tag nibble in the upper half, channel number in the low bits.
  function automatic logic [7:0] header_byte(input logic [2:0] ch);
    return {HEADER_TAG, 1'b0, ch};
  endfunction

endpackage

// File: rtl/sample_buffer_reader_if.sv
// Byte stream valid/ready link carrying the read-out frame.
// Optional feature macro: SAMPLE_READER_CHECKSUM_EN (no effect on this interface).
interface sample_buffer_reader_if;
  import sample_buf_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sample_buffer_reader_bank.sv
// NUM_CHANNELS x DEPTH sample shift storage with a single write port and a
// combinational whole-channel read bus (element 0 = oldest sample).
// Optional feature macro: SAMPLE_READER_CHECKSUM_EN (no effect on this block).
module sample_channel_bank
  import sample_buf_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 7,
  parameter int unsigned DEPTH        = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [2:0]                    wr_ch_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [2:0]                    rd_ch_i,
  output logic [DEPTH-1:0][DATA_W-1:0]  rd_bus_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q [NUM_CHANNELS];

  // Shift the addressed channel down one slot, newest sample enters at the top.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        mem_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_en_i && (wr_ch_i == 3'(c))) begin
          mem_q[c] <= {wr_data_i, mem_q[c][DEPTH-1:1]};
        end
      end
    end
  end

  // Whole-channel read mux; out-of-range channels read as zero.
  always_comb begin
    rd_bus_o = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (rd_ch_i == 3'(c)) begin
        rd_bus_o = mem_q[c];
      end
    end
  end

endmodule

// File: rtl/sample_buffer_reader.sv
// Sample buffer reader: snapshots one channel on request and streams
// header, samples oldest-first and (optionally) an XOR checksum.
// Optional feature macro: SAMPLE_READER_CHECKSUM_EN (adds CSUM state and accumulator).
module sample_buffer_reader
  import sample_buf_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 7,
  parameter int unsigned DEPTH        = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [2:0]                    wr_ch,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_start,
  input  logic [2:0]                    rd_ch,
  output logic                          busy,
  output logic                          rd_err,
  sample_buffer_reader_if.master        out_if
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [3:0] NCH = 4'(NUM_CHANNELS);

  state_t                       state_q;
  logic [DEPTH-1:0][DATA_W-1:0] snap_q;
  logic [IDX_W-1:0]             idx_q;
  logic [DATA_W-1:0]            out_data_q;
  logic                         out_valid_q;
  logic                         busy_q;
  logic                         rd_err_q;
`ifdef SAMPLE_READER_CHECKSUM_EN
  logic [DATA_W-1:0]            csum_q;
`endif

  logic [DEPTH-1:0][DATA_W-1:0] bank_bus;
  logic                         start_ok;
  logic                         hs;
  logic [IDX_W-1:0]             idx_nxt;

  sample_channel_bank #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DEPTH        (DEPTH)
  ) u_bank (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (wr_en),
    .wr_ch_i   (wr_ch),
    .wr_data_i (wr_data),
    .rd_ch_i   (rd_ch),
    .rd_bus_o  (bank_bus)
  );

  // Start qualification, output handshake and next sample index.
  always_comb begin
    start_ok = (state_q == IDLE) && rd_start && ({1'b0, rd_ch} < NCH);
    hs       = out_valid_q && out_if.out_ready;
    idx_nxt  = idx_q + 1'b1;
  end

  // Frame FSM with registered stream outputs. The bank bus reflects pre-write
  // storage, so a same-cycle write to the read channel is not captured.
  // Each data byte is folded into the checksum as it is loaded, so the
  // checksum is complete when the last sample is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_err_q    <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      rd_err_q <= rd_start && !start_ok;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q     <= HEADER;
            snap_q      <= bank_bus;
            idx_q       <= '0;
            out_data_q  <= header_byte(rd_ch);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum_q      <= header_byte(rd_ch);
`endif
          end
        end
        HEADER: begin
          if (hs) begin
            state_q    <= DATA;
            idx_q      <= '0;
            out_data_q <= snap_q[0];
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum_q     <= csum_q ^ snap_q[0];
`endif
          end
        end
        DATA: begin
          if (hs) begin
            if (idx_q == IDX_LAST) begin
`ifdef SAMPLE_READER_CHECKSUM_EN
              state_q    <= CSUM;
              out_data_q <= csum_q;
`else
              state_q     <= IDLE;
              out_data_q  <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
`endif
            end else begin
              idx_q      <= idx_nxt;
              out_data_q <= snap_q[idx_nxt];
`ifdef SAMPLE_READER_CHECKSUM_EN
              csum_q     <= csum_q ^ snap_q[idx_nxt];
`endif
            end
          end
        end
`ifdef SAMPLE_READER_CHECKSUM_EN
        CSUM: begin
          if (hs) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign rd_err           = rd_err_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Self-checking bench for sample_buffer_reader: a reference model of the
// channel buffers queues expected frame bytes at read start; a monitor pops
// and compares them on every output handshake.
// Optional feature macro: SAMPLE_READER_CHECKSUM_EN (expects the checksum byte).
module tb_sample_buffer_reader;

  localparam int unsigned NCH = 7;
  localparam int unsigned DEP = 10;
`ifdef SAMPLE_READER_CHECKSUM_EN
  localparam int unsigned FRAME_CYC = DEP + 2;
`else
  localparam int unsigned FRAME_CYC = DEP + 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_ch = '0;
  logic [7:0] wr_data = '0;
  logic       rd_start = 1'b0;
  logic [2:0] rd_ch = '0;
  logic       busy;
  logic       rd_err;

  sample_buffer_reader_if u_if ();

  sample_buffer_reader #(
    .NUM_CHANNELS (NCH),
    .DEPTH        (DEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .rd_start (rd_start),
    .rd_ch    (rd_ch),
    .busy     (busy),
    .rd_err   (rd_err),
    .out_if   (u_if)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] mdl [NCH][DEP];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every accepted byte against the scoreboard.
  always @(negedge clk) begin
    if (!reset && u_if.out_valid && u_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'h0, u_if.out_data}, 32'hFFFF_FFFF);
      end else begin
        check("frame_byte", {24'h0, u_if.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < int'(NCH); c++)
      for (int i = 0; i < int'(DEP); i++)
        mdl[c][i] = 8'h00;
  endtask

  task automatic model_write(input int ch, input logic [7:0] d);
    if (ch < int'(NCH)) begin
      for (int i = 0; i < int'(DEP) - 1; i++) mdl[ch][i] = mdl[ch][i+1];
      mdl[ch][DEP-1] = d;
    end
  endtask

  task automatic push_frame(input int ch);
    logic [7:0] hdr;
    logic [7:0] cs;
    hdr = 8'hA0 | 8'(ch);
    exp_q.push_back(hdr);
    cs = hdr;
    for (int i = 0; i < int'(DEP); i++) begin
      exp_q.push_back(mdl[ch][i]);
      cs = cs ^ mdl[ch][i];
    end
`ifdef SAMPLE_READER_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic write_smp(input int ch, input logic [7:0] d);
    wr_en = 1'b1;
    wr_ch = 3'(ch);
    wr_data = d;
    model_write(ch, d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_read(input int ch);
    rd_start = 1'b1;
    rd_ch = 3'(ch);
    push_frame(ch);
    tick();
    rd_start = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      if (rnd) u_if.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    u_if.out_ready = 1'b1;
    check("drain_in_time", {31'h0, (n < 500)}, 32'h1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    u_if.out_ready = 1'b1;
    model_clear();
    reset = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_rd_err", {31'h0, rd_err}, 0);
    check("rst_out_valid", {31'h0, u_if.out_valid}, 0);
    check("rst_out_data", {24'h0, u_if.out_data}, 0);
    reset = 1'b0;
    tick();

    // 1: basic frame with ready tied high, latency and length
    for (int i = 0; i < int'(DEP); i++) write_smp(2, 8'h11 + 8'(i));
    start_read(2);
    check("hdr_valid", {31'h0, u_if.out_valid}, 1);
    check("hdr_data", {24'h0, u_if.out_data}, 32'hA2);
    check("hdr_busy", {31'h0, busy}, 1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("frame_len", n, FRAME_CYC);
    check("frame_queue_empty", exp_q.size(), 0);
    check("idle_out_valid", {31'h0, u_if.out_valid}, 0);

    // 2: backpressure in DATA holds the byte
    start_read(2);
    repeat (3) tick();
    u_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_valid", {31'h0, u_if.out_valid}, 1);
      check("hold_data", {24'h0, u_if.out_data}, {24'h0, mdl[2][2]});
    end
    u_if.out_ready = 1'b1;
    drain(1'b0);

    // 3: same-cycle write and read start captures pre-write contents
    wr_en = 1'b1;
    wr_ch = 3'd2;
    wr_data = 8'h55;
    rd_start = 1'b1;
    rd_ch = 3'd2;
    push_frame(2);
    model_write(2, 8'h55);
    tick();
    wr_en = 1'b0;
    rd_start = 1'b0;
    drain(1'b0);
    start_read(2);
    drain(1'b0);

    // 4: rejected starts pulse rd_err for one cycle
    rd_start = 1'b1;
    rd_ch = 3'd7;
    tick();
    rd_start = 1'b0;
    check("err_badch_pulse", {31'h0, rd_err}, 1);
    check("err_badch_busy", {31'h0, busy}, 0);
    tick();
    check("err_badch_clear", {31'h0, rd_err}, 0);
    start_read(0);
    tick();
    rd_start = 1'b1;
    rd_ch = 3'd3;
    tick();
    rd_start = 1'b0;
    check("err_busy_pulse", {31'h0, rd_err}, 1);
    tick();
    check("err_busy_clear", {31'h0, rd_err}, 0);
    drain(1'b0);

    // 5: asynchronous reset in the middle of DATA
    for (int i = 0; i < 4; i++) write_smp(4, 8'hC0 + 8'(i));
    start_read(4);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'h0, u_if.out_valid}, 0);
    check("mid_rst_busy", {31'h0, busy}, 0);
    exp_q.delete();
    model_clear();
    tick();
    reset = 1'b0;
    tick();
    start_read(4);
    drain(1'b0);
    start_read(0);
    drain(1'b0);

    // 6: out-of-range write is ignored; random backpressure on read-back
    for (int c = 0; c < int'(NCH); c++)
      for (int i = 0; i < int'(DEP); i++)
        write_smp(c, 8'($urandom_range(0, 255)));
    write_smp(7, 8'hEE);
    for (int c = 0; c < int'(NCH); c++) begin
      start_read(c);
      drain(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sample_buffer_reader.md
Name: sample_buffer_reader

Overview:
Read-side counterpart to the multi-channel sample capture buffers. Holds NUM_CHANNELS shift buffers of DEPTH 8-bit samples, filled through a simple write port. On request, it snapshots one channel and streams it out as a byte frame over a valid/ready interface. The frame is a header byte, then the samples oldest-first, then an optional checksum. It sits between the input sampling logic and the uo_out/uio output mux of the top-level tile.

Parameters:
NUM_CHANNELS, 7, number of sample channels (1..8)
DEPTH, 10, samples held per channel (2..16)
DATA_W, 8, sample width in bits (fixed at 8; the frame format depends on it)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe; shifts wr_data into channel wr_ch
wr_ch  input  3  target channel for the write
wr_data  input  8  sample value
rd_start  input  1  single-cycle request to read out channel rd_ch
rd_ch  input  3  channel to read
busy  output  1  high from accepted rd_start until the last frame byte handshakes
rd_err  output  1  one-cycle pulse when rd_start is rejected
out_data  output  8  frame byte
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the byte when out_valid && out_ready

Behaviour:
- Reset (async assert): all channel buffers are 0, the snapshot is 0, the FSM is in IDLE, and busy, rd_err and out_valid are 0. out_data is 0x00.
- Write: on wr_en with wr_ch < NUM_CHANNELS, the channel shifts down by one sample. wr_data goes into the newest slot and the oldest sample is discarded. wr_ch >= NUM_CHANNELS is ignored silently. Writes are accepted in every FSM state, including to the channel being read.
- Read accept: rd_start in IDLE with rd_ch < NUM_CHANNELS is accepted. If a write hits the same channel in that cycle, the snapshot captures the pre-write contents. busy rises on the next cycle.
- Read reject: rd_start in any non-IDLE state, or with rd_ch >= NUM_CHANNELS, is dropped. rd_err pulses high for exactly one cycle on the next clock.
- FSM states and transitions:
  - IDLE -> HEADER on accepted start.
  - HEADER: out_valid=1, out_data = 0xA0 | rd_ch. On handshake -> DATA with index 0.
  - DATA: out_data = snapshot[index], oldest first. On handshake, index increments. On handshake at index DEPTH-1 -> CSUM (feature on) or IDLE.
  - CSUM: out_data = XOR of the header and all DEPTH data bytes. On handshake -> IDLE.
- Output stability: while out_valid && !out_ready, out_data and out_valid hold constant.
- Throughput: out_valid stays high through the whole frame. With out_ready tied high, a frame takes DEPTH+1 cycles (DEPTH+2 with checksum) after HEADER is entered.
- Latency: start is sampled at cycle N; HEADER is presented at cycle N+1.
- busy is high in HEADER, DATA and CSUM. It drops in the cycle after the final handshake. A new rd_start in that same IDLE cycle is accepted, so back-to-back frames have a one-cycle gap.
- Reset mid-frame: the frame is abandoned immediately, out_valid=0, and no partial byte is completed.
- Index counter: $clog2(DEPTH) bits; it never exceeds DEPTH-1.

Optional Feature:
SAMPLE_READER_CHECKSUM_EN
- Defined: the CSUM state exists and frames are DEPTH+2 bytes, ending with the XOR checksum.
- Undefined: the CSUM state and the checksum accumulator are not built. Frames are DEPTH+1 bytes, and DATA at index DEPTH-1 goes directly to IDLE.

Decomposition:
- Package sample_buf_pkg: state enum (IDLE, HEADER, DATA, CSUM), HEADER_TAG = 4'hA, DATA_W.
- One sub-module, sample_channel_bank: the NUM_CHANNELS x DEPTH shift storage plus the write port, with a combinational whole-channel read bus that feeds the snapshot.
- The FSM, snapshot, counter and checksum stay in the top block.

Test Plan:
1. Reset, then write 0x11..0x1A to channel 2; rd_start with rd_ch=2, out_ready=1 -> bytes A2,11,12,...,1A (plus checksum A2^11^...^1A when enabled); busy is low the cycle after the last byte.
2. Backpressure: during DATA, drop out_ready for 5 cycles -> out_data and out_valid hold; stream resumes with no dropped or duplicated byte.
3. Write 0x55 to channel 2 in the same cycle as rd_start on channel 2 -> frame carries the old contents; a second read shows 0x55 as the newest sample.
4. rd_start with rd_ch=7 (NUM_CHANNELS=7), and rd_start while busy -> rd_err pulses one cycle each, and the frame in flight is unaffected.
5. Assert reset in the middle of DATA -> out_valid and busy drop asynchronously; after release a read of any channel returns all-zero samples.
6. Write to wr_ch=7 -> no channel changes; reads of channels 0..6 are unchanged.
